lsu_byte_sequencer: RTL and testbench
=====================================

Name: lsu_byte_sequencer

Overview:
- Initiator side of the data-memory load/store interface; sits between the execute/memory stage and the byte-addressed data memory.
- Accepts one load or store request per handshake and breaks it into little-endian byte beats over a byte-wide memory port.
- For loads, assembles the returned bytes and applies sign or zero extension.
- Returns one response per request: load data or store completion, plus an error flag.

Parameters:
- ADDR_W, 32, address width of request and memory port
- MEM_BYTES, 2000, size of the data memory in bytes; used for the range check

Ports:
- iClk  in  1  clock
- iRstN  in  1  synchronous active-low reset
- iReqValid  in  1  request valid
- oReqReady  out  1  high only in IDLE
- iReqWrite  in  1  1=store, 0=load
- iFunct3  in  3  RISC-V width/sign select: 000 B, 001 H, 010 W, 100 BU, 101 HU
- iAddress  in  ADDR_W  byte address
- iWriteData  in  32  store data
- oRespValid  out  1  response valid, held until iRespReady
- iRespReady  in  1  response accept
- oReadData  out  32  extended load data; 0 for stores and errors
- oError  out  1  request rejected, no beats issued
- oMemValid  out  1  byte beat valid
- iMemReady  in  1  beat accept
- oMemWrite  out  1  beat is a write
- oMemAddr  out  ADDR_W  beat byte address
- oMemWData  out  8  beat write byte
- iMemRData  in  8  read byte, valid in the handshake cycle (memory read is combinational)

Behaviour:
- Reset (iRstN low at a rising edge): state goes to IDLE. All outputs are 0 except oReqReady, which is 1.
- Reset mid-operation abandons the access. Store bytes already written stay written. No response is produced.
- States: IDLE, BEAT, RESP.
- IDLE:
  - Handshake is iReqValid & oReqReady. On it, latch write, funct3, address, write data.
  - Set beat count N = 1/2/4 from funct3[1:0] and clear beat index k.
  - If the request is illegal, go to RESP with oError=1. Illegal means: funct3 in {011,110,111}; or store with funct3[2]=1; or iAddress+N-1 >= MEM_BYTES.
  - Otherwise go to BEAT.
- BEAT:
  - oMemValid=1, oMemAddr=addr+k, oMemWrite=write, oMemWData=wdata[8k+7:8k].
  - On a beat handshake, a load captures iMemRData into byte lane k. Then k increments.
  - When k==N-1 and the handshake occurs, go to RESP.
  - oMemValid and address are held stable while iMemReady is low. No timeout.
- RESP:
  - oRespValid=1.
  - Load: oReadData is the assembled value. B/H sign-extend from bit 7/15; BU/HU zero-extend; W is unchanged.
  - Store: oReadData=0.
  - On iRespReady, clear oRespValid/oError/oReadData and go to IDLE.
  - oReqReady is 0 here; a new request can be accepted no earlier than the cycle after the response handshake.
- Latency with iMemReady and iRespReady tied high:
  - Request accepted at edge 0; beats occupy cycles 1..N; oRespValid is high in cycle N+1.
  - Throughput is one request per N+2 cycles.
  - An error response is high in cycle 1.
- Address arithmetic is ADDR_W-bit and wraps. The range check uses a one-bit-wider compare so wrap is always flagged as an error.
- Unused read lanes are 0 before extension.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: H/HU with addr[0]!=0, or W with addr[1:0]!=0, is flagged as an error. No beats are issued and the response is in cycle 1.
- Undefined: misaligned accesses are performed bytewise, like aligned ones, with no error.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum typedef (IDLE/BEAT/RESP)
  - function beat_count(funct3) returning 1/2/4, or 0 for illegal
- One sub-module, lsu_load_extend: combinational, takes funct3 and a 32-bit assembled word and returns the extended result. It is instantiated once on the RESP data path.

Test Plan:
- Store word 0xDEADBEEF to addr 0x10, ready high -> beats at 0x10..0x13 with bytes EF,BE,AD,DE in cycles 1-4; response in cycle 5 with oError=0, oReadData=0.
- Load B from 0x10 with memory byte 0xEF -> 0xFFFFFFEF. LBU from the same address -> 0x000000EF. LH of EF,BE -> 0xFFFFBEEF.
- Load W with iMemReady low for 3 cycles on beat 1 -> oMemAddr/oMemValid held stable, no duplicate capture, final data correct, response in cycle 8.
- funct3=011, or store with funct3=100, or LW at addr 1998 (MEM_BYTES=2000) -> no oMemValid; oError=1 in cycle 1; oReadData=0.
- Reset asserted during beat 2 of a store word -> next edge gives IDLE, oReqReady=1, oMemValid=0, no response; a following request completes normally.
- Alignment, depends on the build:
  - With LSU_ALIGN_CHECK_EN: LW at addr 0x11 -> error in cycle 1.
  - Without: LW at 0x11 -> 4 beats at 0x11..0x14, correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and beat-count helper for the byte sequencer
//
// Purpose : RISC-V funct3 encodings for load/store width and sign, the
//           sequencer state type, and the helper that maps funct3 to the
//           number of byte beats (0 marks an encoding with no defined width).
// Ports   : none (package)

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Number of byte beats for an access; 0 flags 011/110/111.
  function automatic logic [2:0] beat_count(input logic [2:0] funct3);
    logic [2:0] n;
    case (funct3)
      F3_B, F3_BU: n = 3'd1;
      F3_H, F3_HU: n = 3'd2;
      F3_W:        n = 3'd4;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of an assembled little-endian load word
//
// Purpose : Combinational. Extends the assembled load value according to
//           funct3: B/H sign-extend from bit 7/15, BU/HU zero-extend,
//           W passes through.
// Ports   : i_funct3 [2:0]  width/sign select
//           i_word   [31:0] assembled bytes, unused lanes already 0
//           o_data   [31:0] extended result

module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{i_word[7]}}, i_word[7:0]};
      F3_H:    o_data = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_data = {24'd0, i_word[7:0]};
      F3_HU:   o_data = {16'd0, i_word[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - splits load/store requests into little-endian byte beats
//
// Purpose : Accepts one load/store request, checks legality and range,
//           issues 1/2/4 byte beats on a byte-wide memory port, assembles
//           load bytes, and returns one response (data or completion + error).
// Build   : define LSU_ALIGN_CHECK_EN to reject misaligned H/HU/W accesses;
//           undefined, misaligned accesses are performed bytewise.
// Ports   : iClk, iRstN                 clock, synchronous active-low reset
//           iReqValid/oReqReady         request handshake (ready only in IDLE)
//           iReqWrite, iFunct3,
//           iAddress, iWriteData        request fields
//           oRespValid/iRespReady       response handshake
//           oReadData, oError           response payload
//           oMemValid/iMemReady         beat handshake
//           oMemWrite, oMemAddr,
//           oMemWData, iMemRData        beat fields (read data valid in handshake cycle)

module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 2000
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqWrite,
  input  logic [2:0]        iFunct3,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [31:0]       iWriteData,
  output logic              oRespValid,
  input  logic              iRespReady,
  output logic [31:0]       oReadData,
  output logic              oError,
  output logic              oMemValid,
  input  logic              iMemReady,
  output logic              oMemWrite,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [7:0]        oMemWData,
  input  logic [7:0]        iMemRData
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_next;

  logic              r_write;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_n;
  logic [1:0]        r_k;
  logic [31:0]       r_rdata;
  logic              r_error;

  logic [2:0]        w_req_n;
  logic [ADDR_W:0]   w_req_last;
  logic              w_out_of_range;
  logic              w_misaligned;
  logic              w_illegal;
  logic              w_req_hs;
  logic              w_beat_hs;
  logic              w_last_beat;
  logic              w_resp_hs;
  logic [31:0]       w_ext_data;

  // Request legality, evaluated on the live request inputs in IDLE.
  assign w_req_n = beat_count(iFunct3);

  // One extra bit so an access that wraps past the top of the address
  // space lands above MEM_BYTES instead of aliasing to a low address.
  assign w_req_last     = {1'b0, iAddress} + (ADDR_W+1)'(w_req_n) - (ADDR_W+1)'(1);
  assign w_out_of_range = (w_req_last >= (ADDR_W+1)'(MEM_BYTES));

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = ((w_req_n == 3'd2) && iAddress[0]) ||
                        ((w_req_n == 3'd4) && (iAddress[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_illegal = (w_req_n == 3'd0) || (iReqWrite && iFunct3[2]) ||
                     w_out_of_range || w_misaligned;

  assign w_req_hs    = iReqValid && (r_state == IDLE);
  assign w_beat_hs   = (r_state == BEAT) && iMemReady;
  assign w_last_beat = ({1'b0, r_k} == (r_n - 3'd1));
  assign w_resp_hs   = (r_state == RESP) && iRespReady;

  lsu_load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_word   (r_rdata),
    .o_data   (w_ext_data)
  );

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    oReqReady    = 1'b0;
    oMemValid    = 1'b0;
    oMemWrite    = 1'b0;
    oMemAddr     = '0;
    oMemWData    = 8'd0;
    oRespValid   = 1'b0;
    oError       = 1'b0;
    oReadData    = 32'd0;
    case (r_state)
      IDLE: begin
        oReqReady = 1'b1;
        if (iReqValid) begin
          w_state_next = w_illegal ? RESP : BEAT;
        end
      end
      BEAT: begin
        oMemValid = 1'b1;
        oMemWrite = r_write;
        oMemAddr  = r_addr + ADDR_W'(r_k);
        case (r_k)
          2'd0:    oMemWData = r_wdata[7:0];
          2'd1:    oMemWData = r_wdata[15:8];
          2'd2:    oMemWData = r_wdata[23:16];
          default: oMemWData = r_wdata[31:24];
        endcase
        if (iMemReady && w_last_beat) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        oRespValid = 1'b1;
        oError     = r_error;
        oReadData  = (r_write || r_error) ? 32'd0 : w_ext_data;
        if (iRespReady) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_n      <= 3'd0;
      r_k      <= 2'd0;
      r_rdata  <= 32'd0;
      r_error  <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_write  <= iReqWrite;
        r_funct3 <= iFunct3;
        r_addr   <= iAddress;
        r_wdata  <= iWriteData;
        r_n      <= w_req_n;
        r_k      <= 2'd0;
        r_rdata  <= 32'd0;  // lanes beyond N stay 0 ahead of extension
        r_error  <= w_illegal;
      end
      if (w_beat_hs) begin
        if (!r_write) begin
          r_rdata[{r_k, 3'b000} +: 8] <= iMemRData;
        end
        r_k <= r_k + 2'd1;
      end
      if (w_resp_hs) begin
        r_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb/tb_lsu_byte_sequencer.sv - self-checking bench for lsu_byte_sequencer

module tb_lsu_byte_sequencer;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iReqWrite = 1'b0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] iAddress = 32'd0;
  logic [31:0] iWriteData = 32'd0;
  logic        oRespValid;
  logic        iRespReady = 1'b1;
  logic [31:0] oReadData;
  logic        oError;
  logic        oMemValid;
  logic        iMemReady = 1'b1;
  logic        oMemWrite;
  logic [31:0] oMemAddr;
  logic [7:0]  oMemWData;
  logic [7:0]  iMemRData;

  lsu_byte_sequencer #(.ADDR_W(32), .MEM_BYTES(2000)) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iReqValid  (iReqValid),
    .oReqReady  (oReqReady),
    .iReqWrite  (iReqWrite),
    .iFunct3    (iFunct3),
    .iAddress   (iAddress),
    .iWriteData (iWriteData),
    .oRespValid (oRespValid),
    .iRespReady (iRespReady),
    .oReadData  (oReadData),
    .oError     (oError),
    .oMemValid  (oMemValid),
    .iMemReady  (iMemReady),
    .oMemWrite  (oMemWrite),
    .oMemAddr   (oMemAddr),
    .oMemWData  (oMemWData),
    .iMemRData  (iMemRData)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [7:0]  wd;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
  } resp_t;

  logic [7:0]  mem [0:2047];
  beat_t       beat_q[$];
  resp_t       resp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beats_seen = 0;
  int          stall_at = 0;
  int          stall_cnt = 0;
  int          resp_start = 0;
  int          last_acc = 0;
  bit          prev_rv = 1'b0;
  bit          got_resp = 1'b0;
  logic [31:0] last_data = 32'd0;
  bit          last_err = 1'b0;

  assign iMemRData = mem[oMemAddr[10:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge iClk) cyc <= cyc + 1;

  // Handshakes complete at the edge: memory write, queue pops.
  always @(posedge iClk) begin
    if (iRstN) begin
      if (oMemValid && iMemReady) begin
        if (oMemWrite) mem[oMemAddr[10:0]] = oMemWData;
        if (beat_q.size() > 0) void'(beat_q.pop_front());
        beats_seen++;
      end
      if (oRespValid && iRespReady) begin
        last_data = oReadData;
        last_err  = oError;
        got_resp  = 1'b1;
        if (resp_q.size() > 0) void'(resp_q.pop_front());
      end
    end
  end

  // Compare process: outputs against the model on every meaningful cycle.
  always @(negedge iClk) begin
    if (iRstN) begin
      if (oMemValid) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'(oMemValid), 32'd0);
        end else begin
          chk("beat_addr", oMemAddr, beat_q[0].addr);
          chk("beat_write", 32'(oMemWrite), 32'(beat_q[0].wr));
          if (beat_q[0].wr) chk("beat_wdata", 32'(oMemWData), 32'(beat_q[0].wd));
        end
        if (stall_cnt > 0 && beats_seen == stall_at) begin
          iMemReady = 1'b0;
          stall_cnt--;
        end else begin
          iMemReady = 1'b1;
        end
      end else begin
        iMemReady = 1'b1;
      end
      if (oRespValid) begin
        if (!prev_rv) resp_start = cyc;
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'(oRespValid), 32'd0);
        end else begin
          chk("resp_data", oReadData, resp_q[0].data);
          chk("resp_err", 32'(oError), 32'(resp_q[0].err));
        end
      end else begin
        chk("idle_error_low", 32'(oError), 32'd0);
      end
    end
    prev_rv = oRespValid;
  end

  // Behavioural model: legality, beat list and extended load value.
  task automatic model_push(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
    int     n;
    bit     bad;
    longint u;
    resp_t  r;
    beat_t  b;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    if (!bad && (longint'(a) + n - 1 >= 2000)) bad = 1;
`ifdef LSU_ALIGN_CHECK_EN
    if ((n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0)) bad = 1;
`endif
    r.err  = bad;
    r.data = 32'd0;
    if (!bad) begin
      u = 0;
      for (int k = 0; k < n; k++) begin
        b.addr = a + k;
        b.wr   = wr;
        b.wd   = 8'((wd >> (8 * k)) & 32'hFF);
        beat_q.push_back(b);
        u += longint'(mem[b.addr[10:0]]) << (8 * k);
      end
      if (!f3[2] && n < 4 && u >= (longint'(1) << (8 * n - 1))) u -= (longint'(1) << (8 * n));
      if (!wr) r.data = u[31:0];
    end
    resp_q.push_back(r);
  endtask

  // Issue one request; entered and left at negedge+1.
  task automatic issue(input string nm, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_data, input bit exp_err, input int exp_lat);
    int b;
    int h;
    h = hold;
    b = 0;
    while (!oReqReady && b < 50) begin
      @(negedge iClk); #1;
      b++;
    end
    chk({nm, "_req_ready"}, 32'(oReqReady), 32'd1);
    model_push(wr, f3, a, wd);
    beats_seen = 0;
    got_resp   = 1'b0;
    iReqValid  = 1'b1;
    iReqWrite  = wr;
    iFunct3    = f3;
    iAddress   = a;
    iWriteData = wd;
    iRespReady = (h == 0);
    @(negedge iClk);
    last_acc = cyc;
    #1;
    iReqValid = 1'b0;
    b = 0;
    while (!got_resp && b < 60) begin
      if (oRespValid && !iRespReady) begin
        if (h > 0) h--;
        if (h == 0) iRespReady = 1'b1;
      end
      @(negedge iClk); #1;
      b++;
    end
    chk({nm, "_resp_seen"}, 32'(got_resp), 32'd1);
    chk({nm, "_data"}, last_data, exp_data);
    chk({nm, "_err"}, 32'(last_err), 32'(exp_err));
    chk({nm, "_latency"}, 32'(resp_start - last_acc + 1), 32'(exp_lat));
    iRespReady = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    iRstN = 1'b0;
    repeat (2) @(negedge iClk);
    #1;
    chk("rst_req_ready", 32'(oReqReady), 32'd1);
    chk("rst_mem_valid", 32'(oMemValid), 32'd0);
    chk("rst_resp_valid", 32'(oRespValid), 32'd0);
    chk("rst_error", 32'(oError), 32'd0);
    chk("rst_read_data", oReadData, 32'd0);
    chk("rst_mem_addr", oMemAddr, 32'd0);
    iRstN = 1'b1;
    @(negedge iClk); #1;

    issue("sw_10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'd0, 0, 5);
    chk("sw_10_mem", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
    issue("lb_10", 0, 3'b000, 32'h10, 32'd0, 0, 32'hFFFFFFEF, 0, 2);
    issue("lbu_10", 0, 3'b100, 32'h10, 32'd0, 0, 32'h000000EF, 0, 2);
    issue("lh_10", 0, 3'b001, 32'h10, 32'd0, 2, 32'hFFFFBEEF, 0, 3);
    issue("lhu_12", 0, 3'b101, 32'h12, 32'd0, 0, 32'h0000DEAD, 0, 3);

    stall_at  = 0;
    stall_cnt = 3;
    issue("lw_stall", 0, 3'b010, 32'h10, 32'd0, 0, 32'hDEADBEEF, 0, 8);
    stall_cnt = 0;

    issue("f3_011", 0, 3'b011, 32'h10, 32'd0, 0, 32'd0, 1, 1);
    issue("f3_110", 0, 3'b110, 32'h10, 32'd0, 0, 32'd0, 1, 1);
    issue("sbu", 1, 3'b100, 32'h20, 32'h55, 0, 32'd0, 1, 1);
    issue("lw_1998", 0, 3'b010, 32'd1998, 32'd0, 0, 32'd0, 1, 1);
    issue("lw_1996", 0, 3'b010, 32'd1996, 32'd0, 0, 32'hCFCECDCC, 0, 5);
    issue("lb_1999", 0, 3'b000, 32'd1999, 32'd0, 0, 32'hFFFFFFCF, 0, 2);
    issue("lw_wrap", 0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, 32'd0, 1, 1);

    issue("tp_a", 0, 3'b000, 32'h30, 32'd0, 0, 32'h00000030, 0, 2);
    acc1 = last_acc;
    issue("tp_b", 0, 3'b000, 32'h31, 32'd0, 0, 32'h00000031, 0, 2);
    chk("throughput_gap", 32'(last_acc - acc1), 32'd3);

`ifdef LSU_ALIGN_CHECK_EN
    issue("lw_11", 0, 3'b010, 32'h11, 32'd0, 0, 32'd0, 1, 1);
`else
    issue("lw_11", 0, 3'b010, 32'h11, 32'd0, 0, 32'h14DEADBE, 0, 5);
`endif

    // Reset while the second byte of a store word is on the port.
    got_resp = 1'b0;
    model_push(1, 3'b010, 32'h40, 32'hCAFEF00D);
    beats_seen = 0;
    iReqValid  = 1'b1;
    iReqWrite  = 1'b1;
    iFunct3    = 3'b010;
    iAddress   = 32'h40;
    iWriteData = 32'hCAFEF00D;
    @(negedge iClk); #1;
    iReqValid = 1'b0;
    @(negedge iClk); #1;
    iRstN = 1'b0;
    beat_q.delete();
    resp_q.delete();
    @(negedge iClk); #1;
    chk("mid_rst_req_ready", 32'(oReqReady), 32'd1);
    chk("mid_rst_mem_valid", 32'(oMemValid), 32'd0);
    chk("mid_rst_resp_valid", 32'(oRespValid), 32'd0);
    chk("mid_rst_no_resp", 32'(got_resp), 32'd0);
    chk("mid_rst_mem", {mem[16'h41], mem[16'h40]}, 32'h0000410D);
    iRstN = 1'b1;
    @(negedge iClk); #1;
    issue("lw_40", 0, 3'b010, 32'h40, 32'd0, 0, 32'h4342410D, 0, 5);

    repeat (3) @(negedge iClk);
    chk("end_beat_q_empty", 32'(beat_q.size()), 32'd0);
    chk("end_resp_q_empty", 32'(resp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
